// File: rtl/drive_controller.sv
// Ignition and gear-selector sequencer: crank timing, shift interlocks, fuel-out stall.
// Optional idle stop-and-go is compiled in with `define IDLE_STOP_EN.
module drive_controller #(
  parameter int CRANK_SEC     = 2,
  parameter int IDLE_STOP_SEC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1sec,
  input  logic       start_btn,
  input  logic       shift_up,
  input  logic       shift_down,
  input  logic       is_brake_normal,
  input  logic       is_brake_hard,
  input  logic [7:0] speed,
  input  logic [7:0] fuel,
  output logic       engine_on,
  output logic [3:0] current_gear,
  output logic [1:0] eng_state,
  output logic       shift_reject,
  output logic       stall
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_CRANK = 2'd1,
    S_RUN   = 2'd2,
    S_ISG   = 2'd3
  } state_t;

  localparam logic [3:0] G_P = 4'd3;
  localparam logic [3:0] G_R = 4'd6;
  localparam logic [3:0] G_N = 4'd9;
  localparam logic [3:0] G_D = 4'd12;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gear, w_gear_nxt;
  logic       r_reject, w_reject_nxt;
  logic       r_stall, w_stall_nxt;
  logic       r_engine_on;
  logic [2:0] r_crank_cnt, w_crank_nxt, w_crank_inc;

  logic w_brake, w_spd0, w_fuel0;
  logic w_up_only, w_dn_only, w_shift_req;
  logic [3:0] w_shift_gear;
  logic       w_shift_ok;

  assign w_brake     = is_brake_normal | is_brake_hard;
  assign w_spd0      = (speed == 8'd0);
  assign w_fuel0     = (fuel == 8'd0);
  assign w_up_only   = shift_up & ~shift_down;
  assign w_dn_only   = shift_down & ~shift_up;
  assign w_shift_req = w_up_only | w_dn_only;
  assign w_crank_inc = (r_crank_cnt == 3'd7) ? r_crank_cnt : r_crank_cnt + 3'd1;

`ifdef IDLE_STOP_EN
  logic [7:0] r_idle_cnt, w_idle_nxt, w_idle_inc;
  logic       w_idle_cond;
  assign w_idle_inc  = (r_idle_cnt == 8'hFF) ? r_idle_cnt : r_idle_cnt + 8'd1;
  assign w_idle_cond = (r_gear == G_D) & w_spd0 & w_brake;
`endif

  // Target gear of a single-direction shift and whether the interlocks allow it.
  always_comb begin
    w_shift_gear = r_gear;
    w_shift_ok   = 1'b0;
    if (w_up_only) begin
      case (r_gear)
        G_P: begin w_shift_gear = G_R; w_shift_ok = w_brake & w_spd0; end
        G_R: begin w_shift_gear = G_N; w_shift_ok = 1'b1; end
        G_N: begin w_shift_gear = G_D; w_shift_ok = 1'b1; end
        default: w_shift_ok = 1'b0;
      endcase
    end else if (w_dn_only) begin
      case (r_gear)
        G_D: begin w_shift_gear = G_N; w_shift_ok = 1'b1; end
        G_N: begin w_shift_gear = G_R; w_shift_ok = w_spd0; end
        G_R: begin w_shift_gear = G_P; w_shift_ok = w_spd0; end
        default: w_shift_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gear_nxt   = r_gear;
    w_reject_nxt = 1'b0;
    w_stall_nxt  = r_stall;
    w_crank_nxt  = r_crank_cnt;
`ifdef IDLE_STOP_EN
    w_idle_nxt   = r_idle_cnt;
`endif
    case (r_state)
      S_OFF: begin
        w_reject_nxt = w_shift_req;
        if (start_btn && w_brake && !w_fuel0 && (r_gear == G_P || r_gear == G_N)) begin
          w_state_nxt = S_CRANK;
          w_stall_nxt = 1'b0;
        end
      end
      S_CRANK: begin
        w_reject_nxt = w_shift_req;
        if (w_fuel0) begin
          w_state_nxt = S_OFF;
        end else if (tick_1sec) begin
          w_crank_nxt = w_crank_inc;
          if (int'(w_crank_inc) >= CRANK_SEC) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Fuel-out beats start, and start beats any shift in the same cycle.
        if (w_fuel0) begin
          w_state_nxt = S_OFF;
          w_stall_nxt = 1'b1;
        end else if (start_btn) begin
          if (w_spd0) begin
            w_state_nxt = S_OFF;
            w_gear_nxt  = G_P;
          end
        end else if (w_shift_req) begin
          if (w_shift_ok) w_gear_nxt = w_shift_gear;
          else            w_reject_nxt = 1'b1;
        end
`ifdef IDLE_STOP_EN
        if (w_state_nxt == S_RUN) begin
          if (!w_idle_cond) begin
            w_idle_nxt = 8'd0;
          end else if (tick_1sec) begin
            w_idle_nxt = w_idle_inc;
            if (int'(w_idle_inc) >= IDLE_STOP_SEC) w_state_nxt = S_ISG;
          end
        end
`endif
      end
      default: begin
`ifdef IDLE_STOP_EN
        if (w_fuel0) begin
          w_state_nxt = S_OFF;
          w_stall_nxt = 1'b1;
        end else if (start_btn) begin
          w_state_nxt = S_OFF;
          w_gear_nxt  = G_P;
        end else if (!w_brake || shift_up || shift_down) begin
          w_state_nxt = S_RUN;
        end
`else
        w_state_nxt = S_OFF;
`endif
      end
    endcase
    if (w_state_nxt != r_state) begin
      w_crank_nxt = 3'd0;
`ifdef IDLE_STOP_EN
      w_idle_nxt  = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_OFF;
      r_gear      <= G_P;
      r_reject    <= 1'b0;
      r_stall     <= 1'b0;
      r_engine_on <= 1'b0;
      r_crank_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_gear      <= w_gear_nxt;
      r_reject    <= w_reject_nxt;
      r_stall     <= w_stall_nxt;
      r_engine_on <= (w_state_nxt == S_RUN);
      r_crank_cnt <= w_crank_nxt;
    end
  end

`ifdef IDLE_STOP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_idle_cnt <= 8'd0;
    else     r_idle_cnt <= w_idle_nxt;
  end
`endif

  assign engine_on    = r_engine_on;
  assign current_gear = r_gear;
  assign eng_state    = r_state;
  assign shift_reject = r_reject;
  assign stall        = r_stall;

endmodule

// File: tb/tb_drive_controller.sv
// Directed testbench for drive_controller (default CRANK_SEC=2, IDLE_STOP_SEC=3).
module tb_drive_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1sec, start_btn, shift_up, shift_down;
  logic       is_brake_normal, is_brake_hard;
  logic [7:0] speed, fuel;
  logic       engine_on, shift_reject, stall;
  logic [3:0] current_gear;
  logic [1:0] eng_state;

  int n_chk = 0;
  int n_err = 0;

  drive_controller dut (
    .clk(clk), .rst(rst), .tick_1sec(tick_1sec), .start_btn(start_btn),
    .shift_up(shift_up), .shift_down(shift_down),
    .is_brake_normal(is_brake_normal), .is_brake_hard(is_brake_hard),
    .speed(speed), .fuel(fuel), .engine_on(engine_on),
    .current_gear(current_gear), .eng_state(eng_state),
    .shift_reject(shift_reject), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1sec = 1'b1; step(); tick_1sec = 1'b0; step();
  endtask

  task automatic press_start();
    start_btn = 1'b1; step(); start_btn = 1'b0;
  endtask

  task automatic shift(input logic up, input logic dn);
    shift_up = up; shift_down = dn; step(); shift_up = 1'b0; shift_down = 1'b0;
  endtask

  task automatic to_run();
    is_brake_normal = 1'b1; press_start(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1; tick_1sec = 0; start_btn = 0; shift_up = 0; shift_down = 0;
    is_brake_normal = 0; is_brake_hard = 0; speed = 8'd0; fuel = 8'd50;
    step(); step();
    chk("rst_engine", engine_on, 0);
    chk("rst_gear", current_gear, 3);
    chk("rst_state", eng_state, 0);
    chk("rst_reject", shift_reject, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0; step();

    shift(1, 0);
    chk("off_shift_rej", shift_reject, 1);
    chk("off_shift_gear", current_gear, 3);
    step();
    chk("rej_one_cycle", shift_reject, 0);

    press_start();
    chk("start_nobrake", eng_state, 0);

    is_brake_hard = 1'b1; press_start(); is_brake_hard = 1'b0;
    chk("crank_entry", eng_state, 1);
    chk("crank_engine", engine_on, 0);
    tick();
    chk("crank_1tick", eng_state, 1);
    tick();
    chk("run_2tick", eng_state, 2);
    chk("run_engine", engine_on, 1);

    is_brake_normal = 1'b0;
    shift(1, 0);
    chk("p_up_nobrake_rej", shift_reject, 1);
    chk("p_up_nobrake_gear", current_gear, 3);
    is_brake_normal = 1'b1;
    shift(1, 0);
    chk("p_up_brake_gear", current_gear, 6);
    chk("p_up_brake_rej", shift_reject, 0);
    is_brake_normal = 1'b0;
    shift(1, 0); shift(1, 0);
    chk("to_d_gear", current_gear, 12);
    shift(1, 0);
    chk("d_up_rej", shift_reject, 1);
    chk("d_up_gear", current_gear, 12);

    speed = 8'd30;
    shift(0, 1);
    chk("d_down_spd", current_gear, 9);
    shift(0, 1);
    chk("n_down_spd_rej", shift_reject, 1);
    chk("n_down_spd_gear", current_gear, 9);
    shift(1, 0);
    shift(1, 1);
    chk("both_gear", current_gear, 12);
    chk("both_norej", shift_reject, 0);

    press_start();
    chk("stop_moving", eng_state, 2);
    speed = 8'd0;
    start_btn = 1'b1; shift_down = 1'b1; step(); start_btn = 1'b0; shift_down = 1'b0;
    chk("shutdown_state", eng_state, 0);
    chk("shutdown_gear", current_gear, 3);
    chk("shutdown_engine", engine_on, 0);
    chk("shutdown_norej", shift_reject, 0);

    to_run();
    chk("rerun_state", eng_state, 2);
    shift(1, 0); shift(1, 0);
    chk("to_n_gear", current_gear, 9);
    is_brake_normal = 1'b0; speed = 8'd60; fuel = 8'd0; step();
    chk("fuelout_state", eng_state, 0);
    chk("fuelout_stall", stall, 1);
    chk("fuelout_gear", current_gear, 9);
    chk("fuelout_engine", engine_on, 0);
    speed = 8'd0; fuel = 8'd50; is_brake_normal = 1'b1; press_start();
    chk("restart_state", eng_state, 1);
    chk("restart_stall_clr", stall, 0);
    fuel = 8'd0; step();
    chk("crank_fuelout", eng_state, 0);

    fuel = 8'd50; press_start();
    chk("crank_again", eng_state, 1);
    #2 rst = 1'b1; #1;
    chk("async_rst_state", eng_state, 0);
    chk("async_rst_gear", current_gear, 3);
    rst = 1'b0; step();

    to_run();
    fuel = 8'd0; start_btn = 1'b1; step(); start_btn = 1'b0; fuel = 8'd50;
    chk("fuel_start_state", eng_state, 0);
    chk("fuel_start_stall", stall, 1);

`ifdef IDLE_STOP_EN
    to_run();
    shift(1, 0); shift(1, 0); shift(1, 0);
    chk("isg_to_d", current_gear, 12);
    tick(); tick();
    chk("isg_2tick", eng_state, 2);
    tick();
    chk("isg_state", eng_state, 3);
    chk("isg_engine", engine_on, 0);
    is_brake_normal = 1'b0; step();
    chk("isg_exit_state", eng_state, 2);
    chk("isg_exit_engine", engine_on, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
